// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

    // Controller states: waiting for operands, stepping digits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest representable signed value of a w-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value of a w-bit word (only the sign bit set), zero-extended.
    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice built from single-bit full adders.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    logic [DIGIT:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c_s[i]),
            .s  (s[i]),
            .co (c_s[i+1])
        );
    end

    assign cout = c_s[DIGIT];
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with signed overflow
// detection, optional saturation and valid/ready handshakes on both sides.
// One DIGIT-wide adder slice is reused for WIDTH/DIGIT cycles per operation.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry
);
    localparam int                N          = WIDTH / DIGIT;
    localparam int                IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N - 1);
    localparam logic [63:0]       SAT_POS_64 = max_pos(WIDTH);
    localparam logic [63:0]       SAT_NEG_64 = min_neg(WIDTH);
    localparam logic [WIDTH-1:0]  SAT_POS    = SAT_POS_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  SAT_NEG    = SAT_NEG_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    // Elaboration-time parameter legality.
    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_serial: WIDTH must be at least 2");
    end
    if (WIDTH > 64) begin : g_wide_width
        $error("addsub_serial: WIDTH above 64 exceeds the saturation constant range");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("addsub_serial: WIDTH must be a multiple of DIGIT");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;        // already inverted for subtraction
    logic               sat_q;
    logic               cy_q;       // running carry between digits
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;
    logic               carry_q;
    logic               out_valid_q;

    logic [31:0]        shamt_s;
    logic [DIGIT-1:0]   a_dig_s;
    logic [DIGIT-1:0]   b_dig_s;
    logic [DIGIT-1:0]   sum_s;
    logic               cout_s;
    logic [WIDTH-1:0]   raw_s;
    logic [WIDTH-1:0]   final_s;
    logic               ovf_s;

    // Select the current digit of both operands and merge the fresh sum digit into the result word.
    always_comb begin
        shamt_s = 32'(idx_q) * 32'(DIGIT);
        a_dig_s = DIGIT'(a_q >> shamt_s);
        b_dig_s = DIGIT'(b_q >> shamt_s);
        raw_s   = (result_q & ~(DIGIT_MASK << shamt_s)) | (WIDTH'(sum_s) << shamt_s);
    end

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x    (a_dig_s),
        .y    (b_dig_s),
        .cin  (cy_q),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Signed overflow from operand/result sign bits, and clamping when saturation is enabled.
    always_comb begin
        ovf_s = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_s[WIDTH-1] != a_q[WIDTH-1]);
        if (sat_q && ovf_s) begin
            final_s = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
        end else begin
            final_s = raw_s;
        end
    end

    // Controller: accept operands, step one digit per cycle, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sat_q       <= 1'b0;
            cy_q        <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        sat_q    <= sat;
                        cy_q     <= sub;   // +1 completes the two's-complement negation
                        idx_q    <= '0;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        carry_q  <= 1'b0;
                        state_q  <= CALC;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                CALC: begin
                    cy_q <= cout_s;
                    if (idx_q == IDX_LAST) begin
                        result_q    <= final_s;
                        ovf_q       <= ovf_s;
                        carry_q     <= cout_s;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        result_q    <= raw_s;
                        idx_q       <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomised checks of addsub_serial (16/4 and legacy 4/4 configurations).
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, sub, sat, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, ovf, carry;
    logic [15:0] result;

    logic        l_in_valid, l_sub, l_sat, l_out_ready;
    logic [3:0]  l_a, l_b, l_result;
    logic        l_in_ready, l_out_valid, l_ovf, l_carry;

    typedef struct packed {
        logic [15:0] r;
        logic        ovf;
        logic        carry;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .carry     (carry)
    );

    addsub_serial #(.WIDTH(4), .DIGIT(4)) u_leg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .a         (l_a),
        .b         (l_b),
        .sub       (l_sub),
        .sat       (l_sat),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .result    (l_result),
        .ovf       (l_ovf),
        .carry     (l_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour for WIDTH=16, written from the arithmetic definition.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic st);
        exp_t        e;
        logic [15:0] yy;
        logic [16:0] full;
        yy      = s ? ~y : y;
        full    = {1'b0, x} + {1'b0, yy} + {16'd0, s};
        e.r     = full[15:0];
        e.carry = full[16];
        e.ovf   = (x[15] == yy[15]) && (e.r[15] != x[15]);
        if (st && e.ovf) e.r = x[15] ? 16'h8000 : 16'h7FFF;
        return e;
    endfunction

    // One full operation on the 16-bit DUT; hold = cycles of out_ready backpressure.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input logic st, input exp_t e, input string tag, input int hold);
        int   lat;
        exp_t got;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = x; b = y; sub = s; sat = st;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~s; sat = ~st;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        got = sb_q.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(got.r));
        chk({tag, "_ovf"}, 32'(ovf), 32'(got.ovf));
        chk({tag, "_carry"}, 32'(carry), 32'(got.carry));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'h5A5A; b = 16'h0F0F;
            @(negedge clk);
            chk({tag, "_hold_result"}, 32'(result), 32'(got.r));
            chk({tag, "_hold_ovf"}, 32'(ovf), 32'(got.ovf));
            chk({tag, "_hold_carry"}, 32'(carry), 32'(got.carry));
            chk({tag, "_hold_valid"}, {31'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        if (hold > 0) begin
            @(negedge clk);
            chk({tag, "_no_late_accept"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    // One operation on the legacy 4-bit instance.
    task automatic leg_op(input logic [3:0] x, input logic [3:0] y, input logic st,
                          input logic [3:0] er, input logic eo, input logic ec, input string tag);
        int lat;
        @(negedge clk);
        l_in_valid = 1'b1; l_a = x; l_b = y; l_sub = 1'b1; l_sat = st;
        @(posedge clk);
        @(negedge clk);
        l_in_valid = 1'b0; l_a = 4'd0; l_b = 4'd0;
        lat = 0;
        while (l_out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd1);
        chk({tag, "_result"}, 32'(l_result), 32'(er));
        chk({tag, "_ovf"}, 32'(l_ovf), 32'(eo));
        chk({tag, "_carry"}, 32'(l_carry), 32'(ec));
        l_out_ready = 1'b1;
        @(negedge clk);
        l_out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, l_out_valid, l_in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic        rs, rt;
        rst_n = 1'b0;
        in_valid = 1'b0; a = 16'd0; b = 16'd0; sub = 1'b0; sat = 1'b0; out_ready = 1'b0;
        l_in_valid = 1'b0; l_a = 4'd0; l_b = 4'd0; l_sub = 1'b0; l_sat = 1'b0; l_out_ready = 1'b0;
        #12;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", {29'd0, ovf, carry, out_valid}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, '{r: 16'h0007, ovf: 1'b0, carry: 1'b0}, "add_3_4", 0);
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0, '{r: 16'h0002, ovf: 1'b0, carry: 1'b1}, "sub_5_3", 0);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b0, '{r: 16'hFFFE, ovf: 1'b0, carry: 1'b0}, "sub_3_5", 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{r: 16'h8000, ovf: 1'b1, carry: 1'b0}, "ovf_wrap", 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, '{r: 16'h7FFF, ovf: 1'b1, carry: 1'b0}, "ovf_sat_pos", 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, '{r: 16'h8000, ovf: 1'b1, carry: 1'b1}, "ovf_sat_neg", 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, '{r: 16'h0000, ovf: 1'b1, carry: 1'b1}, "add_neg_wrap", 0);
        run_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, '{r: 16'h2143, ovf: 1'b0, carry: 1'b0}, "backpressure", 10);

        // Asynchronous reset in the middle of the digit loop.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; sat = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_result", 32'(result), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_flags", {30'd0, ovf, carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1234, 16'h0101, 1'b0, 1'b0, '{r: 16'h1335, ovf: 1'b0, carry: 1'b0}, "after_reset", 0);

        for (int k = 0; k < 6; k++) begin
            rx = 16'($urandom); ry = 16'($urandom);
            rs = 1'($urandom); rt = 1'($urandom);
            if (k == 0) begin rx = 16'h9000; ry = 16'h7000; rs = 1'b1; rt = 1'b1; end
            run_op(rx, ry, rs, rt, model(rx, ry, rs, rt), $sformatf("rand%0d", k), 0);
        end

        leg_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, "leg_wrap");
        leg_op(4'b0111, 4'b1111, 1'b1, 4'b0111, 1'b1, 1'b0, "leg_sat");
        leg_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1, "leg_plain");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial two's-complement adder/subtractor with overflow detection, selectable saturation and a valid/ready handshake on both sides. It generalises the team's fixed 4-bit overflow-checked subtractor: it supports arbitrary width, runtime add/subtract mode, wrap or saturate on overflow, and a carry/borrow flag. It processes DIGIT bits per clock, so wide operands need only a narrow adder. It sits between operand-producing and result-consuming stages in the datapath.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- DIGIT, 4: bits processed per cycle; WIDTH % DIGIT == 0 is required, checked by elaboration assertion. N = WIDTH/DIGIT.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  minuend / augend, signed.
- b  in  WIDTH  subtrahend / addend, signed.
- sub  in  1  1 = a−b, 0 = a+b; sampled at acceptance.
- sat  in  1  1 = saturate on overflow, 0 = wrap; sampled at acceptance.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference.
- ovf  out  1  signed overflow occurred. Raised even when saturated.
- carry  out  1  final carry out. For sub, 1 = no borrow (a ≥ b unsigned).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid:
  - latch a, sub?~b:b, sub, sat.
  - cin = sub; digit index = 0.
  - go to CALC.
- CALC: each cycle adds digit[idx] of both latched operands plus carry register, writes DIGIT sum bits into result shift/position register, updates carry, idx++. After digit N−1: compute flags, go to DONE.
- Overflow (signed): ovf = (a_msb == b'_msb) && (r_msb != a_msb), where b' is the inverted operand for sub.
- Saturation: if sat && ovf, result = a_msb ? {1,0…0} (most negative) : {0,1…1} (most positive). Otherwise result = raw wrapped value. Never drive Z or X.
- DONE: out_valid=1. result, ovf and carry are held stable until out_ready=1, then go to IDLE.
- Input changes outside the acceptance cycle are ignored. in_valid in CALC or DONE is not accepted.
- Reset (any state, mid-computation included): state=IDLE, in_ready=1 (combinational from state), out_valid=0, result=0, ovf=0, carry=0, idx=0. Any partial result is discarded.

## Timing
- Acceptance edge E0. Digits are computed on E1…EN. out_valid rises after EN: latency N cycles (4 for defaults).
- Minimum issue interval: N+2 cycles (accept, N calc edges, handshake edge, back in IDLE).
- in_ready and out_valid are never high simultaneously.
- Flags and saturated result are valid in the same cycle out_valid rises.
- WIDTH=DIGIT (N=1) is legal: single CALC cycle.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, CALC, DONE).
  - saturation constant functions max_pos(WIDTH) and min_neg(WIDTH).
- Sub-module addsub_digit: DIGIT-bit ripple adder built from chained full_adder instances. Ports: x, y, cin → s, cout. The top instantiates it once.
- Top holds the FSM, operand registers, digit index counter, carry register, result register, and flag/saturation logic.

## Test plan
- WIDTH=16, add, sat=0: 0x0003+0x0004 → result 0x0007, ovf 0, carry 0, out_valid exactly 4 cycles after acceptance.
- Sub, sat=0: 0x0005−0x0003 → 0x0002, carry 1, ovf 0. Then 0x0003−0x0005 → 0xFFFE, carry 0, ovf 0.
- Overflow: 0x7FFF+0x0001 with sat=0 → 0x8000, ovf 1. With sat=1 → 0x7FFF, ovf 1. Also 0x8000−0x0001 with sat=1 → 0x8000, ovf 1.
- Backpressure: hold out_ready=0 for 10 cycles → result and flags stable, in_ready 0, a new in_valid is not accepted. Then out_ready=1 → IDLE the next cycle.
- Reset mid-CALC (digit 2 of 4): rst_n low asynchronously → out_valid 0, result 0, in_ready 1 immediately. The next operation computes correctly.
- Legacy config WIDTH=4, DIGIT=4, sub: 0111−1111 → ovf 1. Result 1000 with sat=0, 0111 with sat=1. Latency 1 cycle.
